// File: rtl/rtc_pkg.sv
// Shared time-of-day types and helpers for the RTC alarm unit.
// Time values are packed {hh[16:12], mm[11:6], ss[5:0]}.
package rtc_pkg;

  localparam int TIME_W = 17;
  localparam int HH_MSB = 16;
  localparam int HH_LSB = 12;
  localparam int MM_MSB = 11;
  localparam int MM_LSB = 6;
  localparam int SS_MSB = 5;
  localparam int SS_LSB = 0;

  typedef logic [TIME_W-1:0] hms_t;

  typedef enum logic [1:0] {
    ALM_IDLE    = 2'd0,
    ALM_ARMED   = 2'd1,
    ALM_RINGING = 2'd2,
    ALM_SNOOZED = 2'd3
  } alm_state_e;

  function automatic logic hms_valid(input hms_t t);
    return (t[HH_MSB:HH_LSB] <= 5'd23) &&
           (t[MM_MSB:MM_LSB] <= 6'd59) &&
           (t[SS_MSB:SS_LSB] <= 6'd59);
  endfunction

  // Advance by one second with the full 23:59:59 -> 00:00:00 carry chain.
  function automatic hms_t hms_inc_sec(input hms_t t);
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    hh = t[HH_MSB:HH_LSB];
    mm = t[MM_MSB:MM_LSB];
    ss = t[SS_MSB:SS_LSB];
    if (ss != 6'd59) begin
      ss = ss + 6'd1;
    end else begin
      ss = '0;
      if (mm != 6'd59) begin
        mm = mm + 6'd1;
      end else begin
        mm = '0;
        hh = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end
    end
    return {hh, mm, ss};
  endfunction

  // Add n minutes (n <= 59) to a valid time, wrapping at 24 h; seconds are kept.
  function automatic hms_t hms_add_min(input hms_t t, input logic [5:0] n);
    logic [6:0] msum;
    logic [4:0] hh;
    msum = {1'b0, t[MM_MSB:MM_LSB]} + {1'b0, n};
    hh   = t[HH_MSB:HH_LSB];
    if (msum >= 7'd60) begin
      msum = msum - 7'd60;
      hh   = hh + 5'd1;
    end
    if (hh >= 5'd24) hh = hh - 5'd24;
    return {hh, msum[5:0], t[SS_MSB:SS_LSB]};
  endfunction

endpackage

// File: rtl/rtc_alarm_ch.sv
// One alarm channel: stored alarm time, ring/snooze FSM, snooze target and ring timer.
// Match and snooze events compare against the time value the counter takes this edge.
module rtc_alarm_ch
  import rtc_pkg::*;
#(
  parameter int BUZZ_SECS  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [TIME_W-1:0] wr_time,
  input  logic              wr_en,
  input  logic              ack,
  input  logic              snooze,
  input  logic              tick,
  input  logic [TIME_W-1:0] time_nx,
  output logic              buzz
);

  localparam int RW = (BUZZ_SECS > 1) ? $clog2(BUZZ_SECS) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(BUZZ_SECS - 1);
  localparam logic [5:0]    SNZ_MIN   = 6'(SNOOZE_MIN);

  alm_state_e    state, state_nx;
  hms_t          alm_time, alm_time_nx;
  logic          alm_ok, alm_ok_nx;
  hms_t          snz_time, snz_time_nx;
  logic [RW-1:0] ring_cnt, ring_cnt_nx;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
    state_nx    = state;
    alm_time_nx = alm_time;
    alm_ok_nx   = alm_ok;
    snz_time_nx = snz_time;
    ring_cnt_nx = ring_cnt;

    if (wr) begin
      alm_time_nx = wr_time;
      alm_ok_nx   = hms_valid(wr_time);
      ring_cnt_nx = '0;
      state_nx    = wr_en ? ALM_ARMED : ALM_IDLE;
    end else begin
      unique case (state)
        ALM_ARMED: begin
          if (tick && alm_ok && (time_nx == alm_time)) begin
            state_nx    = ALM_RINGING;
            ring_cnt_nx = '0;
          end
        end
        ALM_RINGING: begin
          if (ack) begin
            state_nx = ALM_ARMED;
          end else if (snooze) begin
            state_nx    = ALM_SNOOZED;
            snz_time_nx = hms_add_min(time_nx, SNZ_MIN);
          end else if (tick) begin
            if (ring_cnt == RING_LAST) state_nx = ALM_ARMED;
            else ring_cnt_nx = ring_cnt + 1'b1;
          end
        end
        ALM_SNOOZED: begin
          if (ack) begin
            state_nx = ALM_ARMED;
          end else if (tick && (time_nx == snz_time)) begin
            state_nx    = ALM_RINGING;
            ring_cnt_nx = '0;
          end
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

  // NOTE: the stored alarm and snooze times are a handful of flops, so they take the async reset like the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ALM_IDLE;
      alm_time <= '0;
      alm_ok   <= 1'b0;
      snz_time <= '0;
      ring_cnt <= '0;
      buzz     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
      state    <= state_nx;
      alm_time <= alm_time_nx;
      alm_ok   <= alm_ok_nx;
      snz_time <= snz_time_nx;
      ring_cnt <= ring_cnt_nx;
      buzz     <= (state_nx == ALM_RINGING);
    end
  end

endmodule

// File: rtl/rtc_alarm_unit.sv
// Time-of-day core: second prescaler, hh:mm:ss counter with validated load handshake,
// 12/24 h display formatter and NUM_ALM independent alarm channels.
module rtc_alarm_unit
  import rtc_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int NUM_ALM    = 4,
  parameter int BUZZ_SECS  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            set_valid,
  output logic                                            set_ready,
  input  logic [TIME_W-1:0]                               set_time,
  output logic                                            set_err,
  input  logic                                            fmt_12h,
  input  logic                                            alm_wr,
  input  logic [$clog2((NUM_ALM > 1) ? NUM_ALM : 2)-1:0]  alm_idx,
  input  logic [TIME_W-1:0]                               alm_time,
  input  logic                                            alm_en,
  input  logic [NUM_ALM-1:0]                              ack,
  input  logic [NUM_ALM-1:0]                              snooze,
  output logic [TIME_W-1:0]                               time_out,
  output logic                                            pm,
  output logic                                            sec_pulse,
  output logic [NUM_ALM-1:0]                              buzz,
  output logic                                            buzz_any
);

  localparam int IW = $clog2((NUM_ALM > 1) ? NUM_ALM : 2);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  hms_t          cur_time;
  hms_t          time_nx;
  logic          accept;
  logic          set_ok;
  logic          load;
  logic          tick;
  logic          tick_eff;
  logic [4:0]    cur_hh;
  logic [4:0]    disp_hh;

  assign accept   = set_valid & set_ready;
  assign set_ok   = hms_valid(set_time);
  assign load     = accept & set_ok;
  assign tick     = (presc == PRESC_LAST);
  // A valid load in the wrap cycle replaces the time, so that second is dropped entirely.
  assign tick_eff = tick & ~load;

  always_comb begin
    time_nx = cur_time;
    if (load) time_nx = set_time;
    else if (tick) time_nx = hms_inc_sec(cur_time);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      cur_time  <= '0;
      sec_pulse <= 1'b0;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
    end else begin
      presc     <= (load || tick) ? '0 : presc + 1'b1;
      cur_time  <= time_nx;
      sec_pulse <= tick_eff;
      set_ready <= ~accept;
      set_err   <= accept & ~set_ok;
    end
  end

  // 12 h display: 00 and 12 both show as 12, 13..23 fold down to 1..11.
  assign cur_hh = cur_time[HH_MSB:HH_LSB];

  always_comb begin
    disp_hh = cur_hh;
    if (fmt_12h) begin
      if ((cur_hh == 5'd0) || (cur_hh == 5'd12)) disp_hh = 5'd12;
      else if (cur_hh > 5'd12) disp_hh = cur_hh - 5'd12;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_out <= '0;
      pm       <= 1'b0;
    end else begin
      time_out <= {disp_hh, cur_time[MM_MSB:0]};
      pm       <= fmt_12h & (cur_hh >= 5'd12);
    end
  end

  for (genvar i = 0; i < NUM_ALM; i++) begin : g_ch
    logic ch_wr;
    // Indices at or above NUM_ALM decode to no channel and are dropped.
    assign ch_wr = alm_wr && (alm_idx == IW'(i));

    rtc_alarm_ch #(
      .BUZZ_SECS  (BUZZ_SECS),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr      (ch_wr),
      .wr_time (alm_time),
      .wr_en   (alm_en),
      .ack     (ack[i]),
      .snooze  (snooze[i]),
      .tick    (tick_eff),
      .time_nx (time_nx),
      .buzz    (buzz[i])
    );
  end

  assign buzz_any = |buzz;

endmodule
